// File: rtl/thermo_dac_seq.sv
// Thermometer DAC sequencer: static/triangle/sawtooth/raw code source driving a registered unary cell vector.
// Latency: code_out updates on the tick edge, thermo_out follows one cycle later; raw frames appear on the committing tick.
// Backpressure: load_ready drops once a full raw frame is pending and rises again on commit. Optional: THERMO_DAC_DWA_EN.
module thermo_dac_seq #(
    parameter int CODE_W = 8,
    parameter int OUT_W  = 2**CODE_W,
    parameter int LOAD_W = 8,
    parameter int PRE_W  = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [1:0]        mode,
    input  logic              step_en,
    input  logic              hold,
    input  logic [PRE_W-1:0]  prescale,
    input  logic [CODE_W-1:0] code_in,
    input  logic              load_valid,
    input  logic [LOAD_W-1:0] load_data,
    output logic              load_ready,
    output logic [OUT_W-1:0]  thermo_out,
    output logic [CODE_W-1:0] code_out,
    output logic              wrap_pulse,
    output logic              frame_pending
);

    localparam int NCHUNK = OUT_W / LOAD_W;
    localparam int CNT_W  = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
    localparam logic [CODE_W-1:0] MAX = '1;

    localparam logic [1:0] M_STATIC = 2'b00;
    localparam logic [1:0] M_TRI    = 2'b01;
    localparam logic [1:0] M_SAW    = 2'b10;
    localparam logic [1:0] M_RAW    = 2'b11;

    typedef enum logic {DIR_UP = 1'b0, DIR_DOWN = 1'b1} dir_t;

    logic [1:0]        mode_q;
    logic              mode_chg;
    logic [PRE_W-1:0]  pre_cnt;
    logic [PRE_W-1:0]  pre_cnt_nxt;
    logic              tick;
    dir_t              dir_q;
    dir_t              dir_nxt;
    logic [CODE_W-1:0] code_q;
    logic [CODE_W-1:0] code_nxt;
    logic              wrap_nxt;
    logic [OUT_W-1:0]  shreg;
    logic [CNT_W-1:0]  chunk_cnt;
    logic              load_hs;
    logic              commit;

    function automatic logic [OUT_W-1:0] to_unary(input logic [CODE_W-1:0] c);
        logic [OUT_W-1:0] u;
        u = '0;
        for (int i = 0; i < OUT_W; i++) begin
            u[i] = (i < int'(c));
        end
        return u;
    endfunction

    // A mode switch restarts the prescaler so the new mode starts from a clean count.
    always_comb begin
        mode_chg    = (mode != mode_q);
        tick        = 1'b0;
        pre_cnt_nxt = pre_cnt;
        if (mode_chg) begin
            pre_cnt_nxt = '0;
        end else if (step_en && !hold) begin
            if (pre_cnt == prescale) begin
                tick        = 1'b1;
                pre_cnt_nxt = '0;
            end else begin
                pre_cnt_nxt = pre_cnt + PRE_W'(1);
            end
        end
    end

    always_comb begin
        code_nxt = code_q;
        dir_nxt  = dir_q;
        wrap_nxt = 1'b0;
        if (mode_chg) begin
            dir_nxt = DIR_UP;
        end else if (tick) begin
            case (mode)
                M_STATIC: code_nxt = code_in;
                M_TRI: begin
                    if (dir_q == DIR_UP) begin
                        if (code_q == MAX) begin
                            code_nxt = MAX - CODE_W'(1);
                            dir_nxt  = DIR_DOWN;
                        end else begin
                            code_nxt = code_q + CODE_W'(1);
                        end
                    end else if (code_q == '0) begin
                        code_nxt = CODE_W'(1);
                        dir_nxt  = DIR_UP;
                        wrap_nxt = 1'b1;
                    end else begin
                        code_nxt = code_q - CODE_W'(1);
                    end
                end
                M_SAW: begin
                    code_nxt = code_q + CODE_W'(1);
                    wrap_nxt = (code_q == MAX);
                end
                default: code_nxt = code_q;
            endcase
        end
    end

    assign load_ready = rst_n & ~frame_pending;
    assign load_hs    = load_valid & load_ready;
    assign commit     = tick & (mode == M_RAW) & frame_pending;
    assign code_out   = code_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mode_q     <= M_STATIC;
            pre_cnt    <= '0;
            dir_q      <= DIR_UP;
            code_q     <= '0;
            wrap_pulse <= 1'b0;
        end else begin
            mode_q     <= mode;
            pre_cnt    <= pre_cnt_nxt;
            dir_q      <= dir_nxt;
            code_q     <= code_nxt;
            wrap_pulse <= wrap_nxt;
        end
    end

    // Chunks enter at the LSB end, so the first chunk of a frame lands in the top bits.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shreg         <= '0;
            chunk_cnt     <= '0;
            frame_pending <= 1'b0;
        end else if (load_hs) begin
            shreg <= (shreg << LOAD_W) | OUT_W'(load_data);
            if (chunk_cnt == CNT_W'(NCHUNK - 1)) begin
                chunk_cnt     <= '0;
                frame_pending <= 1'b1;
            end else begin
                chunk_cnt <= chunk_cnt + CNT_W'(1);
            end
        end else if (commit) begin
            frame_pending <= 1'b0;
        end
    end

`ifdef THERMO_DAC_DWA_EN
    logic [CODE_W-1:0] ptr;
    logic              tick_d;

    function automatic logic [OUT_W-1:0] rotl(input logic [OUT_W-1:0] v, input logic [CODE_W-1:0] s);
        return (v << s) | (v >> (OUT_W - int'(s)));
    endfunction

    // The pointer advances when the new code reaches the cells, so each code uses the rotation left by its predecessor.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tick_d     <= 1'b0;
            ptr        <= '0;
            thermo_out <= '0;
        end else begin
            tick_d <= tick & (mode != M_RAW);
            if (commit) begin
                thermo_out <= shreg;
            end else if (tick_d && (mode != M_RAW)) begin
                thermo_out <= rotl(to_unary(code_q), ptr);
                ptr        <= ptr + code_q;
            end
        end
    end
`else
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            thermo_out <= '0;
        end else if (commit) begin
            thermo_out <= shreg;
        end else if (mode != M_RAW) begin
            thermo_out <= to_unary(code_q);
        end
    end
`endif

endmodule

// File: tb/tb_thermo_dac_seq.sv
// Scoreboarded bench for thermo_dac_seq: random stimulus against a phase/frame based reference model.
module tb_thermo_dac_seq;
    localparam int MAXC = 255;
    localparam int NCH  = 32;

    logic         clk = 1'b0;
    logic         rst_n;
    logic [1:0]   mode;
    logic         step_en;
    logic         hold;
    logic [7:0]   prescale;
    logic [7:0]   code_in;
    logic         load_valid;
    logic [7:0]   load_data;
    logic         load_ready;
    logic [255:0] thermo_out;
    logic [7:0]   code_out;
    logic         wrap_pulse;
    logic         frame_pending;

    always #5 clk = ~clk;

    thermo_dac_seq dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .mode          (mode),
        .step_en       (step_en),
        .hold          (hold),
        .prescale      (prescale),
        .code_in       (code_in),
        .load_valid    (load_valid),
        .load_data     (load_data),
        .load_ready    (load_ready),
        .thermo_out    (thermo_out),
        .code_out      (code_out),
        .wrap_pulse    (wrap_pulse),
        .frame_pending (frame_pending)
    );

    typedef struct {
        logic [7:0]   code;
        logic [255:0] thermo;
        logic         wrap;
        logic         pend;
        logic         rdy;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int   checks = 0;
    int   errors = 0;

    // Reference state: triangle tracked as a phase 0..2*MAX (2*MAX = at zero heading down).
    int           m_mode_q, m_cnt, m_code, m_phase;
    logic [255:0] m_thermo, m_frame;
    bit           m_wrap, m_pend;
    logic [7:0]   m_chunks[$];
    bit           rel_pending;

    task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic void model_reset();
        m_mode_q = 0; m_cnt = 0; m_code = 0; m_phase = 0;
        m_thermo = '0; m_frame = '0; m_wrap = 0; m_pend = 0;
        m_chunks.delete();
    endfunction

    task automatic apply(input int md, input bit se, input bit hd, input int ps, input int ci,
                         input bit lv, input int ld);
        exp_t e;
        bit chg, tk, hs;
        logic [255:0] th_next;
        mode = md[1:0]; step_en = se; hold = hd; prescale = ps[7:0];
        code_in = ci[7:0]; load_valid = lv; load_data = ld[7:0];

        chg = (md != m_mode_q);
        tk  = 0;
        if (chg) begin
            m_cnt   = 0;
            m_phase = m_code;
        end else if (se && !hd) begin
            if (m_cnt == (ps & 255)) begin
                tk = 1; m_cnt = 0;
            end else begin
                m_cnt = (m_cnt + 1) % 256;
            end
        end
        hs = lv && !m_pend;

        th_next = m_thermo;
        if (md != 3) th_next = (256'(1) << m_code) - 256'(1);
        else if (tk && m_pend) begin
            th_next = m_frame;
            m_pend  = 0;
        end

        m_wrap = 0;
        if (tk) begin
            case (md)
                0: m_code = int'(ci[7:0]);
                1: begin
                    if (m_phase == 2 * MAXC) begin
                        m_phase = 1; m_wrap = 1;
                    end else begin
                        m_phase++;
                    end
                    m_code = (m_phase <= MAXC) ? m_phase : 2 * MAXC - m_phase;
                end
                2: begin
                    m_wrap = (m_code == MAXC);
                    m_code = (m_code + 1) % 256;
                end
                default: ;
            endcase
        end

        if (hs) begin
            m_chunks.push_back(ld[7:0]);
            if (m_chunks.size() == NCH) begin
                m_frame = '0;
                foreach (m_chunks[i]) m_frame = (m_frame << 8) | 256'(m_chunks[i]);
                m_chunks.delete();
                m_pend = 1;
            end
        end

        m_thermo = th_next;
        m_mode_q = md;
        e.code = m_code[7:0]; e.thermo = m_thermo; e.wrap = m_wrap;
        e.pend = m_pend; e.rdy = !m_pend;
        sb.push_back(e);
    endtask

    task automatic step(input int md, input bit se, input bit hd, input int ps, input int ci,
                        input bit lv, input int ld);
        @(negedge clk);
        if (rel_pending) begin
            rst_n = 1'b1;
            rel_pending = 0;
        end
        apply(md, se, hd, ps, ci, lv, ld);
    endtask

    task automatic check_reset(input string tag);
        chk({tag, "_code"},   256'(code_out), '0);
        chk({tag, "_thermo"}, thermo_out, '0);
        chk({tag, "_wrap"},   256'(wrap_pulse), '0);
        chk({tag, "_pend"},   256'(frame_pending), '0);
        chk({tag, "_ready"},  256'(load_ready), '0);
    endtask

    task automatic async_reset();
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check_reset("async_reset");
        model_reset();
        rel_pending = 1;
    endtask

    always @(posedge clk) begin
        #1;
        if (sb.size() > 0) begin
            mon_e = sb.pop_front();
            chk("code_out",      256'(code_out),      256'(mon_e.code));
            chk("thermo_out",    thermo_out,          mon_e.thermo);
            chk("wrap_pulse",    256'(wrap_pulse),    256'(mon_e.wrap));
            chk("frame_pending", 256'(frame_pending), 256'(mon_e.pend));
            chk("load_ready",    256'(load_ready),    256'(mon_e.rdy));
        end
    end

    initial begin
        int md, ps;
        rst_n = 1'b0; mode = 2'b00; step_en = 1'b0; hold = 1'b0; prescale = '0;
        code_in = '0; load_valid = 1'b0; load_data = '0;
        model_reset();
        rel_pending = 1;
        #2;
        check_reset("reset_init");

        // Triangle, full period plus wrap, then reset mid-ramp.
        for (int i = 0; i < 530; i++) step(1, 1, 0, 0, int'($urandom), 0, 0);
        for (int i = 0; i < 100; i++) step(1, 1, 0, 0, 0, 0, 0);
        async_reset();

        // Sawtooth at prescale 2 with a 10-cycle hold window.
        for (int i = 0; i < 800; i++) step(2, 1, (i >= 100 && i < 110), 2, 0, 0, 0);

        // Static: directed code 5 then 0, then random.
        for (int i = 0; i < 3; i++) step(0, 1, 0, 0, 5, 0, 0);
        for (int i = 0; i < 3; i++) step(0, 1, 0, 0, 0, 0, 0);
        for (int i = 0; i < 200; i++)
            step(0, $urandom_range(0, 3) != 0, $urandom_range(0, 7) == 0,
                 int'($urandom_range(0, 3)), int'($urandom), 0, 0);

        // Raw: 32 x 0xA5 with valid held, then commit on a tick.
        for (int i = 0; i < 36; i++) step(3, 0, 0, 0, 0, 1, 8'hA5);
        for (int i = 0; i < 3; i++) step(3, 1, 0, 0, 0, 1, 8'hA5);

        // Reset mid-frame, then a fresh random frame commits.
        for (int i = 0; i < 3; i++) step(3, 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 10; i++) step(3, 0, 0, 0, 0, 1, int'($urandom));
        async_reset();
        for (int i = 0; i < 34; i++) step(3, 0, 0, 0, 0, 1, int'($urandom));
        for (int i = 0; i < 2; i++) step(3, 1, 0, 0, 0, 0, 0);

        // Random mix including mode switches and prescale changes.
        md = 1; ps = 0;
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 49) == 0) md = int'($urandom_range(0, 3));
            if ($urandom_range(0, 29) == 0) ps = int'($urandom_range(0, 7));
            step(md, $urandom_range(0, 7) != 0, $urandom_range(0, 15) == 0, ps,
                 int'($urandom), $urandom_range(0, 2) != 0, int'($urandom));
            if (i == 1500) async_reset();
        end

        @(posedge clk);
        #2;
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: got %0d entries left expected 0", sb.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
